// File: rtl/hovalaag_input_queue.sv
// Twin first-word-fall-through input queues feeding the Hovalaag CPU IN1/IN2 ports.
// Underflow (pop of an empty queue) is flagged sticky rather than prevented.

module hovalaag_iq_lane #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = 4,
  parameter int          W           = 12,
  parameter logic [11:0] EMPTY_VALUE = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [W-1:0]      data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic [W-1:0]      head_o,
  output logic [ADDR_W:0]   count_o,
  output logic              underflow_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [ADDR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]         count_q, count_d;
  logic                    uflow_q;
  logic                    empty, full, push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & ~empty;
  assign count_d = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);

  // Storage needs no reset: emptiness gates the head, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      uflow_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (pop_i & empty) uflow_q <= 1'b1;
      count_q <= count_d;
    end
  end

  assign full_o      = full;
  assign head_o      = empty ? W'(EMPTY_VALUE) : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign underflow_o = uflow_q;
endmodule

module hovalaag_input_queue #(
  parameter int          DEPTH       = 16,
  parameter int          ADDR_W      = 4,
  parameter logic [11:0] EMPTY_VALUE = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       wr_data,
  input  logic              wr_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [11:0]       IN1,
  input  logic              IN1_adv,
  output logic [11:0]       IN2,
  input  logic              IN2_adv,
  output logic [ADDR_W:0]   in1_count,
  output logic [ADDR_W:0]   in2_count,
  output logic [1:0]        underflow
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             push, pop, full, uflow;
  logic [NUM_LANES-1:0][11:0]       head;
  logic [NUM_LANES-1:0][ADDR_W:0]   cnt;

  assign push = {wr_valid & wr_sel, wr_valid & ~wr_sel};
  assign pop  = {IN2_adv, IN1_adv};

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_q
    hovalaag_iq_lane #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(12), .EMPTY_VALUE(EMPTY_VALUE)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push[g]),
      .data_i     (wr_data),
      .pop_i      (pop[g]),
      .full_o     (full[g]),
      .head_o     (head[g]),
      .count_o    (cnt[g]),
      .underflow_o(uflow[g])
    );
  end

  // Ready looks only at the selected queue's registered fullness.
  assign wr_ready  = ~full[wr_sel];
  assign IN1       = head[0];
  assign IN2       = head[1];
  assign in1_count = cnt[0];
  assign in2_count = cnt[1];
  assign underflow = uflow;
endmodule

// File: tb/tb_hovalaag_input_queue.sv
// Bench for hovalaag_input_queue: directed scenarios plus biased random traffic,
// every cycle compared against a queue-based reference model.

module tb_hovalaag_input_queue;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, wr_sel, wr_valid, wr_ready, IN1_adv, IN2_adv;
  logic [11:0] wr_data, IN1, IN2;
  logic [4:0]  in1_count, in2_count;
  logic [1:0]  underflow;

  always #5 clk = ~clk;

  hovalaag_input_queue dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .IN1(IN1), .IN1_adv(IN1_adv), .IN2(IN2), .IN2_adv(IN2_adv),
    .in1_count(in1_count), .in2_count(in2_count), .underflow(underflow)
  );

  int unsigned n_chk = 0, n_pass = 0;
  int          mq1[$], mq2[$];
  bit [1:0]    muf;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: drive, compare outputs against model pre-state, advance model, clock.
  task automatic step(input bit r, input bit v, input bit s, input int d,
                      input bit a1, input bit a2);
    bit ok1, ok2;
    rst = r; wr_valid = v; wr_sel = s; wr_data = 12'(d); IN1_adv = a1; IN2_adv = a2;
    #1;
    chk("wr_ready", int'(wr_ready), s ? int'(mq2.size() < DEPTH) : int'(mq1.size() < DEPTH));
    chk("IN1", int'(IN1), mq1.size() > 0 ? mq1[0] : 0);
    chk("IN2", int'(IN2), mq2.size() > 0 ? mq2[0] : 0);
    chk("in1_count", int'(in1_count), mq1.size());
    chk("in2_count", int'(in2_count), mq2.size());
    chk("underflow", int'(underflow), int'(muf));
    if (r) begin
      mq1.delete(); mq2.delete(); muf = 2'b00;
    end else begin
      ok1 = v && !s && mq1.size() < DEPTH;
      ok2 = v &&  s && mq2.size() < DEPTH;
      if (a1) begin if (mq1.size() == 0) muf[0] = 1'b1; else void'(mq1.pop_front()); end
      if (a2) begin if (mq2.size() == 0) muf[1] = 1'b1; else void'(mq2.pop_front()); end
      if (ok1) mq1.push_back(d & 12'hFFF);
      if (ok2) mq2.push_back(d & 12'hFFF);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pushed, popped, cyc, occ, tgt, pp, pa;
    bit v, a;
    rst = 1; wr_valid = 0; wr_sel = 0; wr_data = '0; IN1_adv = 0; IN2_adv = 0;
    muf = 2'b00;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0);
    idle();

    // FWFT order on q1
    for (int i = 1; i <= 3; i++) step(0, 1, 0, i, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    idle();

    // Fill q2, then 17th push refused while popping
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 'h200 + i, 0, 0);
    step(0, 1, 1, 'h2FF, 0, 1);
    idle();
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0, 0, 1);
    idle();

    // Independence
    step(0, 1, 0, 'h111, 0, 0);
    step(0, 1, 1, 'h222, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    idle();
    step(0, 0, 0, 0, 1, 0);

    // Wrap: 40 words through q1 at occupancy cycling 1..5
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 400) begin
      occ = pushed - popped;
      tgt = 1 + (cyc % 5);
      v = (pushed < 40) && (occ < tgt);
      a = (occ > 0) && (occ >= tgt || pushed == 40);
      step(0, v, 0, 'h100 + pushed, 0, a);
      step(0, 0, 0, 0, a, 0);
      if (v) pushed++;
      if (a) popped++;
      cyc++;
    end
    chk("wrap_done", popped, 40);
    idle();

    // Underflow on empty q1, sticky across a later push
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 'hABC, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0);
    idle();

    // Simultaneous push and pop on empty q2
    step(0, 1, 1, 'h3C3, 0, 1);
    idle();

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(0, 1, 0, 'h500 + i, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 'h055, 0, 0);
    idle();

    // Biased random traffic: phases lean toward full, empty and balanced
    for (int ph = 0; ph < 4; ph++) begin
      pp = (ph == 0) ? 90 : (ph == 1) ? 20 : 60;
      pa = (ph == 0) ? 15 : (ph == 1) ? 70 : 40;
      for (int i = 0; i < 600; i++)
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < pp, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 4095)),
             $urandom_range(0, 99) < pa, $urandom_range(0, 99) < pa);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
